// File: rtl/cohort_rr_lock_arbiter.sv
// Round-robin arbiter that locks one requester onto the shared downstream
// channel for a whole multi-beat transaction, releasing it after the last beat.
module cohort_rr_lock_arbiter #(
  parameter int NumRequesters = 4,
  parameter int DataWidth     = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumRequesters-1:0]           req_valid,
  input  logic [NumRequesters*DataWidth-1:0] req_data,
  input  logic [NumRequesters-1:0]           req_last,
  output logic [NumRequesters-1:0]           req_ready,
  output logic                               out_valid,
  output logic [DataWidth-1:0]               out_data,
  output logic                               out_last,
  output logic [$clog2(NumRequesters)-1:0]   out_id,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int IdW = $clog2(NumRequesters);
  localparam logic [IdW:0] NumReq = (IdW+1)'(NumRequesters);
  localparam logic [IdW-1:0] LastId = IdW'(NumRequesters - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] grant_id_q, grant_id_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

  logic           found;
  logic [IdW-1:0] win;
  logic           xfer_last;

  // Index base+off modulo NumRequesters; the sum never reaches 2*N.
  function automatic logic [IdW-1:0] wrap_add(
    input logic [IdW-1:0] base,
    input int unsigned    off
  );
    logic [IdW:0] s;
    s = {1'b0, base} + off[IdW:0];
    if (s >= NumReq) s = s - NumReq;
    return s[IdW-1:0];
  endfunction

  always_comb begin
    logic [IdW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NumRequesters; k++) begin
      idx = wrap_add(rr_ptr_q, k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    req_ready = '0;
    busy      = 1'b0;
    if (state_q == LOCKED) begin
      out_valid            = req_valid[grant_id_q];
      out_data             = req_data[grant_id_q*DataWidth +: DataWidth];
      out_last             = req_last[grant_id_q];
      out_id               = grant_id_q;
      req_ready[grant_id_q] = out_ready;
      busy                 = 1'b1;
    end
  end

  assign xfer_last = out_valid & out_ready & out_last;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = win;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule
